// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB writebacks vs queued long-latency results.
// Ports: clk/resetn; ws_* WB request + ws_hold; lu_* LU offer/ready; rf_* write port; bypass bus; debug trace.
module rf_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_wr_valid,
  input  logic [4:0]  ws_wr_dest,
  input  logic [31:0] ws_wr_data,
  input  logic [31:0] ws_wr_pc,
  output logic        ws_hold,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_dest,
  input  logic [31:0] lu_data,
  input  logic [31:0] lu_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [37:0] rf_to_ds_bus,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_TRIG = WW'(MAX_WAIT - 1);

  typedef enum logic {IDLE, FORCE} state_t;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } lu_ent_t;

  lu_ent_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic [WW-1:0] r_wait;
  state_t        r_state;
  state_t        w_state_nxt;

  logic    w_empty;
  logic    w_full;
  logic    w_push;
  logic    w_pop;
  logic    w_wb_gnt;
  logic    w_blocked;
  lu_ent_t w_head;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == FULL_CNT);
  assign lu_ready = !w_full;
  assign w_push   = lu_valid && !w_full;
  assign w_head   = r_mem[r_rptr];

  // Grants are masked while reset is asserted so the port stays quiet
  // even if WB presents a request during reset.
  assign w_wb_gnt  = resetn && (r_state == IDLE) && ws_wr_valid;
  assign w_pop     = resetn && !w_wb_gnt && !w_empty;
  assign w_blocked = !w_empty && !w_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{dest: lu_dest, data: lu_data, pc: lu_pc};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait <= '0;
    end else if (w_empty || w_pop) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_MAX) begin
      r_wait <= r_wait + WW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_blocked && (r_wait == WAIT_TRIG)) w_state_nxt = FORCE;
      end
      FORCE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ws_hold = (r_state == FORCE);

  // A dest-0 head is still consumed but never reaches the RF or trace.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    debug_wb_pc = '0;
    unique case (1'b1)
      w_wb_gnt: begin
        rf_we       = 1'b1;
        rf_waddr    = ws_wr_dest;
        rf_wdata    = ws_wr_data;
        debug_wb_pc = ws_wr_pc;
      end
      w_pop: begin
        rf_we       = (w_head.dest != 5'd0);
        rf_waddr    = w_head.dest;
        rf_wdata    = w_head.data;
        debug_wb_pc = rf_we ? w_head.pc : 32'd0;
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

  assign rf_to_ds_bus      = {rf_we, rf_waddr, rf_wdata};
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_we ? rf_waddr : 5'd0;
  assign debug_wb_rf_wdata = rf_we ? rf_wdata : 32'd0;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed testbench for rf_wport_arbiter.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_wr_valid;
  logic [4:0]  ws_wr_dest;
  logic [31:0] ws_wr_data;
  logic [31:0] ws_wr_pc;
  logic        ws_hold;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_dest;
  logic [31:0] lu_data;
  logic [31:0] lu_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [37:0] rf_to_ds_bus;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.DEPTH(2), .MAX_WAIT(8)) dut (
    .clk(clk), .resetn(resetn),
    .ws_wr_valid(ws_wr_valid), .ws_wr_dest(ws_wr_dest),
    .ws_wr_data(ws_wr_data), .ws_wr_pc(ws_wr_pc), .ws_hold(ws_hold),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dest(lu_dest),
    .lu_data(lu_data), .lu_pc(lu_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_to_ds_bus(rf_to_ds_bus), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ws_wr_valid = 1'b0; ws_wr_dest = '0; ws_wr_data = '0; ws_wr_pc = '0;
    lu_valid = 1'b1; lu_dest = 5'd3; lu_data = 32'h55; lu_pc = 32'h40;
    repeat (2) cyc();
    total++;
    if (rf_we !== 1'b0) begin
      bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we);
    end
    total++;
    if ({debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} !== 73'd0) begin
      bad++; $display("FAIL reset_debug got pc=%h we=%h n=%h d=%h exp=0",
        debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    total++;
    if (ws_hold !== 1'b0 || lu_ready !== 1'b1) begin
      bad++; $display("FAIL reset_hold_ready got=%b%b exp=01", ws_hold, lu_ready);
    end
    resetn = 1'b1;
    #1;
    total++;
    if (rf_we !== 1'b0) begin
      bad++; $display("FAIL release_no_bypass got=%b exp=0", rf_we);
    end
    cyc();
    lu_valid = 1'b0;
    #1;
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h55) begin
      bad++; $display("FAIL release_first_write got=%b/%0d/%h exp=1/3/55",
        rf_we, rf_waddr, rf_wdata);
    end
    cyc();
  endtask

  task automatic test_idle_write();
    lu_valid = 1'b1; lu_dest = 5'd5; lu_data = 32'h1234; lu_pc = 32'hBFC00010;
    #1;
    total++;
    if (rf_we !== 1'b0) begin
      bad++; $display("FAIL idle_push_cycle got=%b exp=0", rf_we);
    end
    cyc();
    lu_valid = 1'b0;
    #1;
    total++;
    if (rf_to_ds_bus !== {1'b1, 5'd5, 32'h1234}) begin
      bad++; $display("FAIL idle_bus got=%h exp=%h", rf_to_ds_bus, {1'b1, 5'd5, 32'h1234});
    end
    total++;
    if (debug_wb_pc !== 32'hBFC00010 || debug_wb_rf_we !== 4'hF ||
        debug_wb_rf_wnum !== 5'd5 || debug_wb_rf_wdata !== 32'h1234) begin
      bad++; $display("FAIL idle_debug got pc=%h we=%h n=%0d d=%h", debug_wb_pc,
        debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    cyc();
    total++;
    if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin
      bad++; $display("FAIL idle_empty got we=%b rdy=%b exp=0/1", rf_we, lu_ready);
    end
  endtask

  task automatic test_force();
    for (int k = 0; k <= 10; k++) begin
      ws_wr_valid = 1'b1;
      ws_wr_dest  = 5'(10 + k);
      ws_wr_data  = 32'(k);
      ws_wr_pc    = 32'h1000 + 32'(4 * k);
      lu_valid = (k == 0); lu_dest = 5'd9; lu_data = 32'hAAAA; lu_pc = 32'h100;
      #1;
      total++;
      if (k == 9) begin
        if (ws_hold !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9 ||
            rf_wdata !== 32'hAAAA || debug_wb_pc !== 32'h100) begin
          bad++; $display("FAIL force_k%0d got h=%b we=%b a=%0d d=%h pc=%h", k,
            ws_hold, rf_we, rf_waddr, rf_wdata, debug_wb_pc);
        end
      end else begin
        if (ws_hold !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'(10 + k) ||
            debug_wb_pc !== 32'h1000 + 32'(4 * k)) begin
          bad++; $display("FAIL force_wb_k%0d got h=%b we=%b a=%0d pc=%h", k,
            ws_hold, rf_we, rf_waddr, debug_wb_pc);
        end
      end
      cyc();
    end
    ws_wr_valid = 1'b0; lu_valid = 1'b0;
    #1;
    total++;
    if (rf_we !== 1'b0) begin
      bad++; $display("FAIL force_drained got=%b exp=0", rf_we);
    end
    cyc();
  endtask

  task automatic test_full_fifo();
    logic eh, er;
    logic [4:0] ea;
    for (int k = 0; k <= 28; k++) begin
      ws_wr_valid = 1'b1; ws_wr_dest = 5'd20; ws_wr_data = 32'(k); ws_wr_pc = 32'h2000;
      lu_valid = (k <= 10);
      lu_dest  = (k == 0) ? 5'd1 : (k == 1) ? 5'd2 : 5'd3;
      lu_data  = (k == 0) ? 32'hA1 : (k == 1) ? 32'hB2 : 32'hC3;
      lu_pc    = 32'h300 + 32'(lu_dest);
      eh = (k == 9) || (k == 18) || (k == 27);
      er = !((k >= 2 && k <= 9) || (k >= 11 && k <= 18));
      ea = (k == 9) ? 5'd1 : (k == 18) ? 5'd2 : (k == 27) ? 5'd3 : 5'd20;
      #1;
      total++;
      if (ws_hold !== eh || lu_ready !== er || rf_waddr !== ea || rf_we !== 1'b1) begin
        bad++; $display("FAIL full_k%0d got h=%b r=%b a=%0d we=%b exp h=%b r=%b a=%0d we=1",
          k, ws_hold, lu_ready, rf_waddr, rf_we, eh, er, ea);
      end
      cyc();
    end
    ws_wr_valid = 1'b0; lu_valid = 1'b0;
    #1;
    total++;
    if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin
      bad++; $display("FAIL full_drained got we=%b r=%b exp=0/1", rf_we, lu_ready);
    end
    cyc();
  endtask

  task automatic test_dest_zero();
    ws_wr_valid = 1'b0;
    lu_valid = 1'b1; lu_dest = 5'd0; lu_data = 32'hDEAD; lu_pc = 32'h200;
    #1;
    total++;
    if (rf_we !== 1'b0) begin
      bad++; $display("FAIL dz_push got=%b exp=0", rf_we);
    end
    cyc();
    lu_dest = 5'd7; lu_data = 32'h77; lu_pc = 32'h204;
    #1;
    total++;
    if (rf_we !== 1'b0 || debug_wb_rf_we !== 4'h0 || debug_wb_pc !== 32'd0 ||
        debug_wb_rf_wnum !== 5'd0 || debug_wb_rf_wdata !== 32'd0) begin
      bad++; $display("FAIL dz_pop got we=%b dwe=%h pc=%h exp=0", rf_we,
        debug_wb_rf_we, debug_wb_pc);
    end
    cyc();
    lu_valid = 1'b0;
    #1;
    total++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || debug_wb_pc !== 32'h204) begin
      bad++; $display("FAIL dz_next got we=%b a=%0d pc=%h exp=1/7/204", rf_we,
        rf_waddr, debug_wb_pc);
    end
    cyc();
    total++;
    if (rf_we !== 1'b0) begin
      bad++; $display("FAIL dz_empty got=%b exp=0", rf_we);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 9; k++) begin
      ws_wr_valid = 1'b1; ws_wr_dest = 5'd12; ws_wr_data = 32'(k); ws_wr_pc = 32'h4000;
      lu_valid = (k <= 1); lu_dest = 5'(k + 1); lu_data = 32'hE0 + 32'(k); lu_pc = 32'h500;
      if (k < 9) cyc();
    end
    #1;
    total++;
    if (ws_hold !== 1'b1 || lu_ready !== 1'b0) begin
      bad++; $display("FAIL mid_pre got h=%b r=%b exp=1/0", ws_hold, lu_ready);
    end
    resetn = 1'b0;
    #1;
    total++;
    if (ws_hold !== 1'b0 || lu_ready !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("FAIL mid_reset got h=%b r=%b we=%b exp=0/1/0", ws_hold,
        lu_ready, rf_we);
    end
    cyc();
    cyc();
    resetn = 1'b1; ws_wr_valid = 1'b0; lu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (rf_we !== 1'b0) begin
        bad++; $display("FAIL mid_after_k%0d got=%b exp=0", k, rf_we);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_force();
    test_full_fifo();
    test_dest_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
